controller: RTL and testbench
=============================

# controller

Multicycle control unit for the 8-bit MIPS-subset processor. A Moore state machine sequences four byte-wide instruction fetches, decode, and per-instruction execute/memory/writeback steps. A combinational ALU decoder produces `alucontrol` from the instruction class and `funct`. It sits beside the datapath, consuming `op`, `funct` and `zero`, and driving every datapath mux select and write enable.

## Interface
No parameters.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset (0 = reset).
- `op` input 6: instruction opcode, IR[31:26].
- `funct` input 6: R-type function field, IR[5:0].
- `zero` input 1: ALU result-is-zero flag.
- `memread` output 1: memory read enable.
- `memwrite` output 1: memory write enable.
- `alusrca` output 1: ALU A select (0 = PC, 1 = register A).
- `memtoreg` output 1: register write data select (1 = memory data register).
- `iord` output 1: memory address select (0 = PC, 1 = ALU out).
- `pcen` output 1: PC load enable.
- `regwrite` output 1: register file write enable.
- `regdst` output 1: destination register select (1 = rd, 0 = rt).
- `pcsrc` output 2: PC source (00 ALU result, 01 ALU out/branch target, 10 jump target).
- `alusrcb` output 2: ALU B select (00 reg B, 01 constant 1, 10 immediate, 11 immediate for branch offset).
- `alucontrol` output 3: ALU operation.
- `irwrite` output 4: one-hot byte enable for instruction register bytes 0..3.

## Operation
- Opcodes: LB = 100000, SB = 101000, RTYPE = 000000, BEQ = 000100, J = 000010, ADDI = 001000.
- States use a 4-bit encoding: FETCH1..FETCH4, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR.
- Transitions:
  - FETCH1→FETCH2→FETCH3→FETCH4→DECODE.
  - DECODE: LB or SB→MEMADR; RTYPE→RTYPEEX; BEQ→BEQEX; J→JEX; ADDI→ADDIEX; any other opcode→FETCH1.
  - MEMADR: LB→LBRD; otherwise→SBWR.
  - LBRD→LBWR. RTYPEEX→RTYPEWR. ADDIEX→ADDIWR.
  - LBWR, SBWR, RTYPEWR, BEQEX, JEX and ADDIWR each go to FETCH1.
  - Any unused encoding goes to FETCH1.
- Outputs are pure decode of state. Every output not listed for a state is 0; `aluop` is internal.
  - FETCHn: `memread`=1, `irwrite`=one-hot bit n-1, `alusrcb`=01, pcwrite=1, `aluop`=00.
  - DECODE: `alusrcb`=11, `aluop`=00.
  - MEMADR: `alusrca`=1, `alusrcb`=10.
  - LBRD: `memread`=1, `iord`=1.
  - LBWR: `regwrite`=1, `memtoreg`=1.
  - SBWR: `memwrite`=1, `iord`=1.
  - RTYPEEX: `alusrca`=1, `aluop`=10.
  - RTYPEWR: `regdst`=1, `regwrite`=1.
  - BEQEX: `alusrca`=1, `aluop`=01, branch=1, `pcsrc`=01.
  - JEX: pcwrite=1, `pcsrc`=10.
  - ADDIEX: `alusrca`=1, `alusrcb`=10.
  - ADDIWR: `regwrite`=1.
- `pcen` = pcwrite OR (branch AND `zero`). This is combinational, so `zero` affects `pcen` in the same cycle.
- ALU decoder:
  - `aluop` 00 → `alucontrol` 010 (add).
  - `aluop` 01 → 110 (subtract).
  - `aluop` 10 decodes `funct`: 100000→010, 100010→110, 100100→000 (and), 100101→001 (or), 101010→111 (slt). Any other `funct`→010.
  - `aluop` 11 (unused) → 010.

## Timing
- State register updates on the rising edge of `clk`.
- `reset` low forces the state to FETCH1 immediately, without waiting for a clock edge, and holds it there.
- Outputs during and directly after reset are the FETCH1 values: `memread`=1, `irwrite`=0001, `alusrcb`=01, `pcen`=1, `alucontrol`=010; all else 0.
- The first rising edge after `reset` goes high moves to FETCH2.
- Instruction lengths in cycles, FETCH1 through the last state: LB 8, SB 7, RTYPE 7, ADDI 7, BEQ 6, J 6, unknown opcode 5.
- `op` is sampled only in DECODE and MEMADR. `funct` and `zero` act combinationally with no registering.
- Reset asserted mid-instruction aborts the instruction. All write enables drop at once, except the FETCH1 values (`memread`, `irwrite`=0001, `pcen`).

## Test plan
- Reset held low 2 cycles, then released → FETCH1 outputs during reset; `irwrite` steps 0001, 0010, 0100, 1000 on successive cycles, then DECODE with `alusrcb`=11.
- `op`=100000 (LB), `funct`=100000 → MEMADR (`alusrca`=1, `alusrcb`=10), then LBRD (`memread`=1, `iord`=1), then LBWR (`regwrite`=1, `memtoreg`=1), then FETCH1; 8 cycles total.
- `op`=101000 (SB) → SBWR has `memwrite`=1, `iord`=1, then FETCH1. `op`=001000 (ADDI) → ADDIWR has `regwrite`=1, `regdst`=0.
- `op`=000000 with `funct` = 100000 / 100010 / 100100 / 100101 / 101010 / 000000 → RTYPEEX `alucontrol` = 010 / 110 / 000 / 001 / 111 / 010; RTYPEWR has `regdst`=1, `regwrite`=1.
- `op`=000100 (BEQ): in BEQEX, `zero`=1 → `pcen`=1, `pcsrc`=01, `alucontrol`=110; `zero`=0 → `pcen`=0. `op`=000010 (J) → JEX has `pcen`=1, `pcsrc`=10.
- `op`=111111 → DECODE goes straight to FETCH1. `reset` pulsed low during RTYPEWR → `regwrite` drops to 0 before the next clock edge and the state is FETCH1.

Source files
------------

// File: rtl/controller.sv
// Multicycle control unit for the 8-bit MIPS-subset core: a Moore FSM sequencing
// fetch/decode/execute plus a combinational ALU decoder.
module controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic       memtoreg,
  output logic       iord,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic [1:0] pcsrc,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [3:0] irwrite
);

  localparam logic [3:0] FETCH1  = 4'd0;
  localparam logic [3:0] FETCH2  = 4'd1;
  localparam logic [3:0] FETCH3  = 4'd2;
  localparam logic [3:0] FETCH4  = 4'd3;
  localparam logic [3:0] DECODE  = 4'd4;
  localparam logic [3:0] MEMADR  = 4'd5;
  localparam logic [3:0] LBRD    = 4'd6;
  localparam logic [3:0] LBWR    = 4'd7;
  localparam logic [3:0] SBWR    = 4'd8;
  localparam logic [3:0] RTYPEEX = 4'd9;
  localparam logic [3:0] RTYPEWR = 4'd10;
  localparam logic [3:0] BEQEX   = 4'd11;
  localparam logic [3:0] JEX     = 4'd12;
  localparam logic [3:0] ADDIEX  = 4'd13;
  localparam logic [3:0] ADDIWR  = 4'd14;

  localparam logic [5:0] OpLb    = 6'b100000;
  localparam logic [5:0] OpSb    = 6'b101000;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  logic [3:0] state_q, state_d;
  logic       pcwrite, branch;
  logic [1:0] aluop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH1;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH1;
    case (state_q)
      FETCH1:  state_d = FETCH2;
      FETCH2:  state_d = FETCH3;
      FETCH3:  state_d = FETCH4;
      FETCH4:  state_d = DECODE;
      DECODE: begin
        case (op)
          OpLb, OpSb: state_d = MEMADR;
          OpRtype:    state_d = RTYPEEX;
          OpBeq:      state_d = BEQEX;
          OpJ:        state_d = JEX;
          OpAddi:     state_d = ADDIEX;
          default:    state_d = FETCH1;
        endcase
      end
      MEMADR:  state_d = (op == OpLb) ? LBRD : SBWR;
      LBRD:    state_d = LBWR;
      RTYPEEX: state_d = RTYPEWR;
      ADDIEX:  state_d = ADDIWR;
      default: state_d = FETCH1;
    endcase
  end

  always_comb begin
    memread  = 1'b0;
    memwrite = 1'b0;
    alusrca  = 1'b0;
    memtoreg = 1'b0;
    iord     = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    pcsrc    = 2'b00;
    alusrcb  = 2'b00;
    irwrite  = 4'b0000;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    aluop    = 2'b00;
    case (state_q)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        memread = 1'b1;
        irwrite = 4'b0001 << state_q[1:0];
        alusrcb = 2'b01;
        pcwrite = 1'b1;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      LBRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      LBWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      SBWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWR: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        branch  = 1'b1;
        pcsrc   = 2'b01;
      end
      JEX: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWR:  regwrite = 1'b1;
      default: ;
    endcase
  end

  // zero is used unregistered so a taken branch loads the PC in BEQEX itself
  assign pcen = pcwrite | (branch & zero);

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for controller: per-instruction step model feeds a queue of
// expected control words, a negedge monitor pops and compares.
module tb_controller;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic       memtoreg;
    logic       iord;
    logic       pcen;
    logic       regwrite;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [3:0] irwrite;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  ctl_t       dut_o;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  ctl_t exp_q[$];
  string name_q[$];

  controller u_dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memread    (dut_o.memread),
    .memwrite   (dut_o.memwrite),
    .alusrca    (dut_o.alusrca),
    .memtoreg   (dut_o.memtoreg),
    .iord       (dut_o.iord),
    .pcen       (dut_o.pcen),
    .regwrite   (dut_o.regwrite),
    .regdst     (dut_o.regdst),
    .pcsrc      (dut_o.pcsrc),
    .alusrcb    (dut_o.alusrcb),
    .alucontrol (dut_o.alucontrol),
    .irwrite    (dut_o.irwrite)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input ctl_t got, input ctl_t want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b want %b (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Monitor: every cycle the controller presents a control word.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_underflow at t=%0t", $time);
      end else begin
        check(name_q.pop_front(), dut_o, exp_q.pop_front());
      end
    end
  end

  function automatic int instr_len(input logic [5:0] o);
    case (o)
      6'b100000: return 8;
      6'b101000, 6'b000000, 6'b001000: return 7;
      6'b000100, 6'b000010: return 6;
      default: return 5;
    endcase
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic ctl_t fetch1_word();
    ctl_t c = '0;
    c.memread = 1'b1; c.irwrite = 4'b0001; c.alusrcb = 2'b01;
    c.pcen = 1'b1; c.alucontrol = 3'b010;
    return c;
  endfunction

  // Control word expected in step k (0 = first fetch cycle) of an instruction.
  function automatic ctl_t model(input logic [5:0] o, input logic [5:0] f,
                                 input logic z, input int k);
    ctl_t c = '0;
    c.alucontrol = 3'b010;
    if (k < 4) begin
      c.memread = 1'b1; c.irwrite = 4'(1 << k); c.alusrcb = 2'b01; c.pcen = 1'b1;
    end else if (k == 4) begin
      c.alusrcb = 2'b11;
    end else begin
      case (o)
        6'b100000, 6'b101000: begin
          if (k == 5) begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
          else if (o == 6'b101000) begin c.memwrite = 1'b1; c.iord = 1'b1; end
          else if (k == 6) begin c.memread = 1'b1; c.iord = 1'b1; end
          else begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
        end
        6'b000000: begin
          if (k == 5) begin c.alusrca = 1'b1; c.alucontrol = rtype_alu(f); end
          else begin c.regdst = 1'b1; c.regwrite = 1'b1; end
        end
        6'b001000: begin
          if (k == 5) begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
          else c.regwrite = 1'b1;
        end
        6'b000100: begin
          c.alusrca = 1'b1; c.pcsrc = 2'b01; c.alucontrol = 3'b110; c.pcen = z;
        end
        6'b000010: begin c.pcen = 1'b1; c.pcsrc = 2'b10; end
        default: ;
      endcase
    end
    return c;
  endfunction

  // Runs one instruction; zmode -1 = random zero each cycle. abort_step >= 0
  // pulses reset in the middle of that step.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int zmode, input int abort_step);
    int n = instr_len(o);
    op = o;
    funct = f;
    for (int k = 0; k < n; k++) begin
      zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
      exp_q.push_back(model(o, f, zero, k));
      name_q.push_back($sformatf("op%b_f%b_step%0d", o, f, k));
      if (k == abort_step) begin
        @(negedge clk);
        #2;
        reset = 1'b0;
        mon_en = 1'b0;
        #1 check("async_reset_abort", dut_o, fetch1_word());
        @(posedge clk);
        #1 check("reset_hold", dut_o, fetch1_word());
        reset = 1'b1;
        mon_en = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] op_tab [7];
  logic [5:0] fn_tab [6];

  initial begin
    op_tab = '{6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    reset = 1'b0;
    op = 6'b000000;
    funct = 6'b000000;
    zero = 1'b0;
    #1 check("reset_async", dut_o, fetch1_word());
    repeat (2) @(posedge clk);
    @(negedge clk) check("reset_held_2cyc", dut_o, fetch1_word());
    @(posedge clk);
    #1 reset = 1'b1;
    mon_en = 1'b1;

    run_instr(6'b100000, 6'b100000, -1, -1);
    run_instr(6'b101000, 6'b000000, -1, -1);
    run_instr(6'b001000, 6'b000000, -1, -1);
    foreach (fn_tab[i]) run_instr(6'b000000, fn_tab[i], -1, -1);
    run_instr(6'b000100, 6'b000000, 1, -1);
    run_instr(6'b000100, 6'b000000, 0, -1);
    run_instr(6'b000010, 6'b000000, -1, -1);
    run_instr(6'b111111, 6'b000000, -1, -1);
    run_instr(6'b000000, 6'b100101, -1, 6);

    for (int i = 0; i < 300; i++) begin
      logic [5:0] o, f;
      o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 6)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 5)];
      run_instr(o, f, -1, ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1);
    end

    @(negedge clk);
    mon_en = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
